// File: rtl/pe_scan_seq.sv
//------------------------------------------------------------------------------
// pe_scan_seq : captures an N-bit request vector and emits every set-bit index
// in priority order, one per handshake. Optional macro: PE_SCAN_COUNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_scan_seq #(
  parameter int N         = 32,
  parameter int CODE_W    = $clog2(N),
  parameter int LSB_FIRST = 0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] Code,
  output logic              done,
  output logic              empty
`ifdef PE_SCAN_COUNT_EN
  ,
  output logic [CODE_W:0]   count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [N-1:0]      r_pending;
  logic              r_empty;
  logic [CODE_W-1:0] w_idx;
  logic [N-1:0]      w_clr_mask;
  logic [N-1:0]      w_pend_nxt;
  logic              w_last;
  logic              w_fire_in;
  logic              w_fire_out;

  // Last match in loop order wins, so loop direction selects the priority.
  always_comb begin
    w_idx = '0;
    if (LSB_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (r_pending[i]) w_idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_pending[i]) w_idx = CODE_W'(i);
      end
    end
  end

  assign w_clr_mask = N'(1) << w_idx;
  assign w_pend_nxt = r_pending & ~w_clr_mask;
  assign w_last     = ~|w_pend_nxt;
  assign w_fire_in  = in_valid  & (r_state == S_IDLE);
  assign w_fire_out = out_ready & (r_state == S_SCAN);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = (|Data) ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        if (out_ready && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_SCAN:  out_valid = 1'b1;
      S_DONE:  done      = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Index is forced to zero outside SCAN so stale pending bits never leak out.
  assign Code  = (r_state == S_SCAN) ? w_idx : '0;
  assign empty = r_empty;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_pending <= '0;
      r_empty   <= 1'b0;
    end else if (w_fire_in) begin
      r_pending <= Data;
      r_empty   <= ~|Data;
    end else if (w_fire_out) begin
      r_pending <= w_pend_nxt;
    end
  end

`ifdef PE_SCAN_COUNT_EN
  logic [CODE_W:0] r_count;
  logic [CODE_W:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + (CODE_W + 1)'(Data[i]);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_count <= '0;
    end else if (w_fire_in) begin
      r_count <= w_pop;
    end else if (w_fire_out) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_scan_seq.sv
//------------------------------------------------------------------------------
// tb_pe_scan_seq : MSB-first and LSB-first instances driven in lockstep and
// compared against per-instance queues of expected indices.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_scan_seq;

  localparam int N  = 32;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  Data = '0;

  logic          a_in_ready, a_out_valid, a_done, a_empty;
  logic          b_in_ready, b_out_valid, b_done, b_empty;
  logic [CW-1:0] a_code, b_code;
`ifdef PE_SCAN_COUNT_EN
  logic [CW:0]   a_count, b_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int qa[$];
  int qb[$];

  always #5 clock = ~clock;

  pe_scan_seq #(.N(N), .LSB_FIRST(0)) u_msb (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
    .Data(Data), .out_valid(a_out_valid), .out_ready(out_ready), .Code(a_code),
    .done(a_done), .empty(a_empty)
`ifdef PE_SCAN_COUNT_EN
    , .count(a_count)
`endif
  );

  pe_scan_seq #(.N(N), .LSB_FIRST(1)) u_lsb (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .Data(Data), .out_valid(b_out_valid), .out_ready(out_ready), .Code(b_code),
    .done(b_done), .empty(b_empty)
`ifdef PE_SCAN_COUNT_EN
    , .count(b_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_empty);
    check({tag, "_a_in_ready"},  32'(a_in_ready),  1);
    check({tag, "_b_in_ready"},  32'(b_in_ready),  1);
    check({tag, "_a_out_valid"}, 32'(a_out_valid), 0);
    check({tag, "_b_out_valid"}, 32'(b_out_valid), 0);
    check({tag, "_a_code"},      32'(a_code),      0);
    check({tag, "_b_code"},      32'(b_code),      0);
    check({tag, "_a_done"},      32'(a_done),      0);
    check({tag, "_b_done"},      32'(b_done),      0);
    check({tag, "_a_empty"},     32'(a_empty),     32'(exp_empty));
    check({tag, "_b_empty"},     32'(b_empty),     32'(exp_empty));
  endtask

  // mode 0: consumer always ready; 1: random ready; 2: stall three cycles, then ready
  task automatic run_vec(input logic [N-1:0] d, input int mode, input logic prev_empty);
    int   cyc = 0;
    int   stall = 0;
    logic r;
    qa.delete();
    qb.delete();
    for (int i = N - 1; i >= 0; i--) if (d[i]) qa.push_back(i);
    for (int i = 0; i < N; i++)      if (d[i]) qb.push_back(i);

    check_idle("pre", prev_empty);
    Data      = d;
    in_valid  = 1'b1;
    out_ready = (mode == 0);
    tick();
    in_valid = 1'b0;
`ifdef PE_SCAN_COUNT_EN
    check("count_capture", 32'(a_count), qa.size());
`endif
    while (qa.size() > 0) begin
      cyc++;
      if (cyc > 400) begin
        check("scan_timeout", qa.size(), 0);
        break;
      end
      check("a_out_valid", 32'(a_out_valid), 1);
      check("b_out_valid", 32'(b_out_valid), 1);
      check("a_code",      32'(a_code),      qa[0]);
      check("b_code",      32'(b_code),      qb[0]);
      check("scan_in_ready", 32'(a_in_ready | b_in_ready), 0);
      check("scan_done",     32'(a_done | b_done),         0);
`ifdef PE_SCAN_COUNT_EN
      check("a_count", 32'(a_count), qa.size());
      check("b_count", 32'(b_count), qb.size());
`endif
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom % 2);
        default: r = (stall >= 3);
      endcase
      stall++;
      out_ready = r;
      in_valid  = 1'($urandom % 2);
      Data      = $urandom;
      tick();
      if (r) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
    end
    in_valid = 1'b0;
    check("a_done",  32'(a_done),  1);
    check("b_done",  32'(b_done),  1);
    check("a_empty", 32'(a_empty), 32'(d == '0));
    check("b_empty", 32'(b_empty), 32'(d == '0));
    check("done_out_valid", 32'(a_out_valid | b_out_valid), 0);
    check("done_in_ready",  32'(a_in_ready | b_in_ready),   0);
    check("done_code",      32'(a_code | b_code),           0);
`ifdef PE_SCAN_COUNT_EN
    check("done_count", 32'(a_count | b_count), 0);
`endif
    out_ready = 1'($urandom % 2);
    tick();
    check_idle("post", d == '0);
  endtask

  initial begin
    logic [N-1:0] d;
    logic         last_empty;

    tick();
    tick();
    check_idle("reset", 1'b0);
`ifdef PE_SCAN_COUNT_EN
    check("reset_count", 32'(a_count), 0);
`endif
    clear = 1'b0;
    tick();
    check_idle("release", 1'b0);

    run_vec(32'h8000_0001, 0, 1'b0);
    run_vec(32'h0000_0000, 0, 1'b0);
    run_vec(32'h0000_000F, 2, 1'b1);
    run_vec(32'hFFFF_FFFF, 0, 1'b0);
    run_vec(32'h0040_0021, 0, 1'b0);
    run_vec(32'hC000_0001, 1, 1'b0);

    // Clear in the middle of a scan discards the vector without a done pulse.
    Data      = 32'h0000_0105;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("clr_first_a", 32'(a_code), 8);
    check("clr_first_b", 32'(b_code), 0);
    tick();
    check("clr_second_a", 32'(a_code), 2);
    check("clr_second_b", 32'(b_code), 2);
    clear = 1'b1;
    #1;
    check_idle("clr_async", 1'b0);
    tick();
    clear = 1'b0;
    tick();
    check_idle("clr_after", 1'b0);
    tick();
    check_idle("clr_after2", 1'b0);

    last_empty = 1'b0;
    for (int t = 0; t < 40; t++) begin
      case ($urandom % 4)
        0:       d = '0;
        1:       d = $urandom;
        default: d = $urandom & $urandom & $urandom;
      endcase
      run_vec(d, 1, last_empty);
      last_empty = (d == '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
